fpmul_cu: RTL and testbench

Control unit for the multi-cycle IEEE-754 single-precision multiplier datapath. It sequences operand load, exponent add and de-bias, special-operand dispatch, normalization, rounding and under/overflow handling by decoding its state and the datapath status flags into the datapath load, select, set and reset strobes. It sits beside the datapath and presents a start/busy/done handshake to the requester.

---
 rtl/fpmul_pkg.sv | 26 ++
 rtl/fpmul_cu.sv | 182 ++++++++++++++++++
 tb/tb_fpmul_cu.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpmul_pkg.sv
// Shared encodings for the fpmul multi-cycle multiplier control unit.
// State codes and datapath select values are fixed here.
package fpmul_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LOAD = 4'd1,
    MUL  = 4'd2,
    BIAS = 4'd3,
    CHK  = 4'd4,
    NORM = 4'd5,
    RND  = 4'd6,
    EXC  = 4'd7,
    OUT  = 4'd8
  } state_t;

  localparam logic [1:0] EP_ADD  = 2'b00;
  localparam logic [1:0] EP_BIAS = 2'b10;
  localparam logic [1:0] EP_INC  = 2'b01;

  localparam logic [2:0] MPH_MP  = 3'b000;
  localparam logic [2:0] MPH_ONE = 3'b100;
  localparam logic [2:0] MPH_INC = 3'b010;
  localparam logic [2:0] MPH_SHL = 3'b001;

endpackage

// File: rtl/fpmul_cu.sv
// fpmul control unit: sequences load, exponent math, special dispatch,
// normalize, round and exception handling for the multiplier datapath.
module fpmul_cu
  import fpmul_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       Op_NaN,
  input  logic       Op_Inf,
  input  logic       Op_Zero,
  input  logic       MPH23,
  input  logic       Round,
  input  logic       Carry,
  input  logic       UFlow,
  input  logic       OFlow,
  output logic       SA_LD,
  output logic       EA_LD,
  output logic       MA_LD,
  output logic       SB_LD,
  output logic       EB_LD,
  output logic       MB_LD,
  output logic       SP_LD,
  output logic       EP_RST,
  output logic       EP_SET,
  output logic       EP_LD,
  output logic [1:0] EP_SEL,
  output logic       MPH_RST,
  output logic       MPH_SET,
  output logic       MPH_LD,
  output logic [2:0] MPH_SEL,
  output logic       MPL_SEL,
  output logic       MPL_LD,
  output logic       UF_RST,
  output logic       UF_LD,
  output logic       OF_RST,
  output logic       OF_LD,
  output logic       P_RST,
  output logic       P_LD,
  output logic [3:0] state
);

  state_t st, st_n;
  logic   special;

  assign special = Op_NaN | Op_Inf | Op_Zero;
  assign state   = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_n;
  end

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE:    if (start) st_n = LOAD;
      LOAD:    st_n = MUL;
      MUL:     st_n = BIAS;
      BIAS:    st_n = CHK;
      CHK:     st_n = special ? OUT : NORM;
      NORM:    st_n = RND;
      RND:     st_n = EXC;
      EXC:     st_n = OUT;
      OUT:     st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    busy    = (st != IDLE);
    done    = 1'b0;
    SA_LD   = 1'b0;
    EA_LD   = 1'b0;
    MA_LD   = 1'b0;
    SB_LD   = 1'b0;
    EB_LD   = 1'b0;
    MB_LD   = 1'b0;
    SP_LD   = 1'b0;
    EP_RST  = 1'b0;
    EP_SET  = 1'b0;
    EP_LD   = 1'b0;
    EP_SEL  = EP_ADD;
    MPH_RST = 1'b0;
    MPH_SET = 1'b0;
    MPH_LD  = 1'b0;
    MPH_SEL = MPH_MP;
    MPL_SEL = 1'b0;
    MPL_LD  = 1'b0;
    UF_RST  = 1'b0;
    UF_LD   = 1'b0;
    OF_RST  = 1'b0;
    OF_LD   = 1'b0;
    P_RST   = 1'b0;
    P_LD    = 1'b0;
    unique case (st)
      LOAD: begin
        SA_LD  = 1'b1;
        EA_LD  = 1'b1;
        MA_LD  = 1'b1;
        SB_LD  = 1'b1;
        EB_LD  = 1'b1;
        MB_LD  = 1'b1;
        UF_RST = 1'b1;
        OF_RST = 1'b1;
        P_RST  = 1'b1;
      end
      MUL: begin
        EP_SEL  = EP_ADD;
        EP_LD   = 1'b1;
        MPH_SEL = MPH_MP;
        MPH_LD  = 1'b1;
        MPL_SEL = 1'b0;
        MPL_LD  = 1'b1;
        SP_LD   = 1'b1;
      end
      BIAS: begin
        EP_SEL = EP_BIAS;
        EP_LD  = 1'b1;
      end
      CHK: begin
        priority case (1'b1)
          Op_NaN: begin
            EP_SET  = 1'b1;
            MPH_SET = 1'b1;
          end
          Op_Inf: begin
            EP_SET  = 1'b1;
            MPH_RST = 1'b1;
          end
          Op_Zero: begin
            EP_RST  = 1'b1;
            MPH_RST = 1'b1;
          end
          default: ;
        endcase
      end
      NORM: begin
        if (MPH23) begin
          EP_SEL = EP_INC;
          EP_LD  = 1'b1;
        end else begin
          MPH_SEL = MPH_SHL;
          MPH_LD  = 1'b1;
          MPL_SEL = 1'b1;
          MPL_LD  = 1'b1;
        end
      end
      RND: begin
        // A rounding carry-out renormalizes mantissa and exponent together
        if (Round && Carry) begin
          MPH_SEL = MPH_ONE;
          MPH_LD  = 1'b1;
          EP_SEL  = EP_INC;
          EP_LD   = 1'b1;
        end else if (Round) begin
          MPH_SEL = MPH_INC;
          MPH_LD  = 1'b1;
        end
      end
      EXC: begin
        if (UFlow) begin
          UF_LD   = 1'b1;
          EP_RST  = 1'b1;
          MPH_RST = 1'b1;
        end else if (OFlow) begin
          OF_LD   = 1'b1;
          EP_SET  = 1'b1;
          MPH_RST = 1'b1;
        end
      end
      OUT: begin
        P_LD = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpmul_cu.sv
// Scoreboard bench for fpmul_cu: per-operation expected strobe traces
// are queued at issue time and compared by an independent monitor.
module tb_fpmul_cu;

  typedef struct packed {
    logic [3:0] state;
    logic       busy;
    logic       done;
    logic [6:0] lds;
    logic       ep_rst;
    logic       ep_set;
    logic       ep_ld;
    logic [1:0] ep_sel;
    logic       mph_rst;
    logic       mph_set;
    logic       mph_ld;
    logic [2:0] mph_sel;
    logic       mpl_sel;
    logic       mpl_ld;
    logic       uf_rst;
    logic       uf_ld;
    logic       of_rst;
    logic       of_ld;
    logic       p_rst;
    logic       p_ld;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done;
  logic Op_NaN, Op_Inf, Op_Zero, MPH23, Round, Carry, UFlow, OFlow;
  logic SA_LD, EA_LD, MA_LD, SB_LD, EB_LD, MB_LD, SP_LD;
  logic EP_RST, EP_SET, EP_LD;
  logic [1:0] EP_SEL;
  logic MPH_RST, MPH_SET, MPH_LD;
  logic [2:0] MPH_SEL;
  logic MPL_SEL, MPL_LD;
  logic UF_RST, UF_LD, OF_RST, OF_LD, P_RST, P_LD;
  logic [3:0] state;

  vec_t act;
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fpmul_cu dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .Op_NaN(Op_NaN), .Op_Inf(Op_Inf), .Op_Zero(Op_Zero),
    .MPH23(MPH23), .Round(Round), .Carry(Carry),
    .UFlow(UFlow), .OFlow(OFlow),
    .SA_LD(SA_LD), .EA_LD(EA_LD), .MA_LD(MA_LD),
    .SB_LD(SB_LD), .EB_LD(EB_LD), .MB_LD(MB_LD), .SP_LD(SP_LD),
    .EP_RST(EP_RST), .EP_SET(EP_SET), .EP_LD(EP_LD), .EP_SEL(EP_SEL),
    .MPH_RST(MPH_RST), .MPH_SET(MPH_SET), .MPH_LD(MPH_LD),
    .MPH_SEL(MPH_SEL), .MPL_SEL(MPL_SEL), .MPL_LD(MPL_LD),
    .UF_RST(UF_RST), .UF_LD(UF_LD), .OF_RST(OF_RST), .OF_LD(OF_LD),
    .P_RST(P_RST), .P_LD(P_LD), .state(state)
  );

  assign act = {state, busy, done,
                SA_LD, EA_LD, MA_LD, SB_LD, EB_LD, MB_LD, SP_LD,
                EP_RST, EP_SET, EP_LD, EP_SEL,
                MPH_RST, MPH_SET, MPH_LD, MPH_SEL,
                MPL_SEL, MPL_LD,
                UF_RST, UF_LD, OF_RST, OF_LD, P_RST, P_LD};

  // f = {nan, inf, zero, mph23, round, carry, uflow, oflow}
  task automatic push_op(input logic [7:0] f);
    vec_t v;
    v = '0; v.state = 4'd1; v.busy = 1'b1; v.lds = 7'b1111110;
    v.uf_rst = 1'b1; v.of_rst = 1'b1; v.p_rst = 1'b1;
    sb.push_back(v);
    v = '0; v.state = 4'd2; v.busy = 1'b1; v.lds = 7'b0000001;
    v.ep_ld = 1'b1; v.mph_ld = 1'b1; v.mpl_ld = 1'b1;
    sb.push_back(v);
    v = '0; v.state = 4'd3; v.busy = 1'b1;
    v.ep_sel = 2'b10; v.ep_ld = 1'b1;
    sb.push_back(v);
    v = '0; v.state = 4'd4; v.busy = 1'b1;
    if (f[7]) begin
      v.ep_set = 1'b1; v.mph_set = 1'b1;
    end else if (f[6]) begin
      v.ep_set = 1'b1; v.mph_rst = 1'b1;
    end else if (f[5]) begin
      v.ep_rst = 1'b1; v.mph_rst = 1'b1;
    end
    sb.push_back(v);
    if (f[7:5] == 3'b000) begin
      v = '0; v.state = 4'd5; v.busy = 1'b1;
      if (f[4]) begin
        v.ep_sel = 2'b01; v.ep_ld = 1'b1;
      end else begin
        v.mph_sel = 3'b001; v.mph_ld = 1'b1;
        v.mpl_sel = 1'b1; v.mpl_ld = 1'b1;
      end
      sb.push_back(v);
      v = '0; v.state = 4'd6; v.busy = 1'b1;
      if (f[3] && f[2]) begin
        v.mph_sel = 3'b100; v.mph_ld = 1'b1;
        v.ep_sel = 2'b01; v.ep_ld = 1'b1;
      end else if (f[3]) begin
        v.mph_sel = 3'b010; v.mph_ld = 1'b1;
      end
      sb.push_back(v);
      v = '0; v.state = 4'd7; v.busy = 1'b1;
      if (f[1]) begin
        v.uf_ld = 1'b1; v.ep_rst = 1'b1; v.mph_rst = 1'b1;
      end else if (f[0]) begin
        v.of_ld = 1'b1; v.ep_set = 1'b1; v.mph_rst = 1'b1;
      end
      sb.push_back(v);
    end
    v = '0; v.state = 4'd8; v.busy = 1'b1; v.done = 1'b1; v.p_ld = 1'b1;
    sb.push_back(v);
  endtask

  // Monitor: every busy cycle consumes one expected entry; idle must be quiet
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_busy: got %h want idle", act);
        end else begin
          vec_t e;
          e = sb.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL trace: got %h want %h", act, e);
          end
        end
      end else begin
        checks++;
        if (act !== '0) begin
          errors++;
          $display("FAIL idle_quiet: got %h want 0", act);
        end
      end
    end
  end

  task automatic set_flags(input logic [7:0] f);
    {Op_NaN, Op_Inf, Op_Zero, MPH23, Round, Carry, UFlow, OFlow} = f;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL drain_timeout: got queue %0d busy %b want 0 0",
               sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [7:0] f, input bit repulse);
    set_flags(f);
    push_op(f);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    if (repulse) begin
      @(posedge clk); #2;
      @(posedge clk); #2;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
    end
    wait_drain();
    @(posedge clk); #2;
  endtask

  initial begin
    logic [7:0] f;
    int n;
    rst = 1'b1;
    start = 1'b0;
    set_flags(8'h00);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", act);
    end
    rst = 1'b0;
    @(posedge clk); #2;

    run_op(8'b000_1_0_0_0_0, 1'b0);
    run_op(8'b110_0_0_0_0_0, 1'b0);
    run_op(8'b000_0_1_1_0_0, 1'b0);
    run_op(8'b000_1_1_0_1_1, 1'b0);
    run_op(8'b001_0_1_1_0_1, 1'b0);
    run_op(8'b000_0_0_0_0_1, 1'b1);

    // start held high: the second LOAD follows one IDLE cycle after OUT
    f = 8'b000_1_0_0_0_0;
    set_flags(f);
    push_op(f);
    push_op(f);
    start = 1'b1;
    n = 0;
    while (!done && n < 30) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL held_done: got done 0 want 1");
    end
    @(posedge clk); #2;
    checks++;
    if (state !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_gap: got state %0d busy %b want 0 0", state, busy);
    end
    @(posedge clk); #2;
    checks++;
    if (state !== 4'd1) begin
      errors++;
      $display("FAIL held_reload: got state %0d want 1", state);
    end
    start = 1'b0;
    wait_drain();
    @(posedge clk); #2;

    // asynchronous reset while in NORM
    f = 8'b000_0_1_0_0_0;
    set_flags(f);
    push_op(f);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    n = 0;
    while (state !== 4'd5 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (state !== 4'd5) begin
      errors++;
      $display("FAIL reach_norm: got state %0d want 5", state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", act);
    end
    sb.delete();
    #1;
    rst = 1'b0;
    @(posedge clk); #2;
    run_op(8'b000_1_0_0_0_0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      f[7] = ($urandom_range(0, 5) == 0);
      f[6] = ($urandom_range(0, 5) == 0);
      f[5] = ($urandom_range(0, 5) == 0);
      f[4] = 1'($urandom_range(0, 1));
      f[3] = 1'($urandom_range(0, 1));
      f[2] = 1'($urandom_range(0, 1));
      f[1] = ($urandom_range(0, 3) == 0);
      f[0] = ($urandom_range(0, 3) == 0);
      run_op(f, ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
